fusion_pair_sequencer: RTL

- Sits between the two decoders and the fusion scan stage, upstream of issue.
- Buffers decoded scoreboard entries in a small in-order queue and re-pairs them so that two adjacent instructions reach the fusion scan together as often as possible.
- A lone instruction is held for up to WAIT_CYCLES, waiting for a partner, before it is released alone.
- Counts fused pairs for performance monitoring.

---
 rtl/fusion_pair_sequencer_pkg.sv | 22 ++
 rtl/fusion_pair_sequencer.sv | 102 ++++++++++
 2 files changed

// File: rtl/fusion_pair_sequencer_pkg.sv
// Stand-in core configuration and decoded-entry types so the sequencer elaborates without the full core.
// Only ex.valid of the entry is interpreted; everything else passes through untouched.
package fusion_pair_sequencer_pkg;

    typedef struct packed {
        int unsigned nr_issue;
    } cfg_t;

    localparam cfg_t cfg_empty = '{nr_issue: 1};

    typedef struct packed {
        logic       valid;
        logic [3:0] cause;
    } exc_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [7:0]  op;
        exc_t        ex;
    } sb_entry_t;

endpackage

// File: rtl/fusion_pair_sequencer.sv
// In-order re-pairing queue ahead of the fusion scan: presents two adjacent entries whenever
// possible, holds a lone oldest entry briefly for a partner, and counts fused pairs.
module fusion_pair_sequencer
    import fusion_pair_sequencer_pkg::*;
#(
    parameter cfg_t        CVA6Cfg            = cfg_empty,
    parameter type         scoreboard_entry_t = sb_entry_t,
    parameter int unsigned DEPTH              = 4,
    parameter int unsigned WAIT_CYCLES        = 2,
    parameter int unsigned CNT_W              = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_i,
    input  scoreboard_entry_t [1:0]     instr_i,
    input  logic [1:0]                  instr_valid_i,
    output logic                        instr_ready_o,
    output scoreboard_entry_t [1:0]     pair_o,
    output logic [1:0]                  pair_valid_o,
    input  logic                        pair_ready_i,
    input  logic                        fusion_hit_i,
    output logic [CNT_W-1:0]            fused_cnt_o
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned WAIT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [PTR_W:0]    ACC_MAX  = (PTR_W + 1)'(DEPTH - 2);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WAIT_CYCLES);

    scoreboard_entry_t mem_q [DEPTH];

    logic [PTR_W-1:0]  rd_q, wr_q, rd_nxt1, wr_nxt1, wr_sel1;
    logic [PTR_W:0]    cnt_q, push_n, pop_n;
    logic [WAIT_W-1:0] wait_q;
    logic              lone_ok, pop_fire;

    // Accept depends only on registered occupancy so issue back-pressure never reaches decode combinationally.
    assign instr_ready_o = (cnt_q <= ACC_MAX);
    assign rd_nxt1       = rd_q + PTR_W'(1);
    assign wr_nxt1       = wr_q + PTR_W'(1);
    assign wr_sel1       = instr_valid_i[0] ? wr_nxt1 : wr_q;
    assign pair_o[0]     = mem_q[rd_q];
    assign pair_o[1]     = mem_q[rd_nxt1];

    always_comb begin
        push_n = '0;
        if (instr_ready_o)
            push_n = (PTR_W + 1)'(instr_valid_i[0]) + (PTR_W + 1)'(instr_valid_i[1]);

        // An excepting entry cannot fuse, so waiting for a partner gains nothing.
        lone_ok = (WAIT_CYCLES == 0) || (wait_q >= WAIT_MAX) || pair_o[0].ex.valid;

        pair_valid_o = 2'b00;
        if (cnt_q >= (PTR_W + 1)'(2))
            pair_valid_o = 2'b11;
        else if (cnt_q == (PTR_W + 1)'(1) && lone_ok)
            pair_valid_o = 2'b01;

        pop_fire = pair_ready_i && (pair_valid_o != 2'b00);
        pop_n    = '0;
        if (pop_fire)
            pop_n = pair_valid_o[1] ? (PTR_W + 1)'(2) : (PTR_W + 1)'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q        <= '0;
            wr_q        <= '0;
            cnt_q       <= '0;
            wait_q      <= '0;
            fused_cnt_o <= '0;
        end else if (flush_i) begin
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            wait_q <= '0;
        end else begin
            rd_q  <= rd_q + pop_n[PTR_W-1:0];
            wr_q  <= wr_q + push_n[PTR_W-1:0];
            cnt_q <= cnt_q + push_n - pop_n;
            if (cnt_q == (PTR_W + 1)'(1) && push_n == '0 && pop_n == '0) begin
                if (wait_q != WAIT_MAX)
                    wait_q <= wait_q + WAIT_W'(1);
            end else begin
                wait_q <= '0;
            end
            if (pop_fire && pair_valid_o == 2'b11 && fusion_hit_i)
                fused_cnt_o <= fused_cnt_o + CNT_W'(1);
        end
    end

    // Storage needs no reset: occupancy alone decides what is presented.
    always_ff @(posedge clk_i) begin
        if (!flush_i && instr_ready_o) begin
            if (instr_valid_i[0])
                mem_q[wr_q] <= instr_i[0];
            if (instr_valid_i[1])
                mem_q[wr_sel1] <= instr_i[1];
        end
    end

endmodule
